// File: rtl/e203_reset_seq.sv
// rtl/e203_reset_seq.sv - E203 reset sequencer: synchronized POR release of AON, TCM and core
// domains in order, plus watchdog/debug/software warm reset with cause capture.
module e203_reset_seq #(
    parameter int SYNC_LEVELS = 2,
    parameter int AON_HOLD    = 4,
    parameter int MEM_HOLD    = 8,
    parameter int CORE_HOLD   = 16,
    parameter int WARM_HOLD   = 8,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       test_mode,
    input  logic       wdg_rst_req,
    input  logic       sw_rst_req,
    input  logic       dbg_ndmreset,
    output logic       rst_aon_n,
    output logic       rst_mem_n,
    output logic       rst_core_n,
    output logic [1:0] rst_cause,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_POR,
        ST_AON,
        ST_MEM,
        ST_CORE,
        ST_RUN,
        ST_WARM
    } state_t;

    localparam logic [1:0] CAUSE_POR = 2'd0;
    localparam logic [1:0] CAUSE_WDG = 2'd1;
    localparam logic [1:0] CAUSE_DBG = 2'd2;
    localparam logic [1:0] CAUSE_SW  = 2'd3;

    localparam logic [CNT_W-1:0] AON_LOAD  = CNT_W'(AON_HOLD - 1);
    localparam logic [CNT_W-1:0] MEM_LOAD  = CNT_W'(MEM_HOLD - 1);
    localparam logic [CNT_W-1:0] CORE_LOAD = CNT_W'(CORE_HOLD - 1);
    localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARM_HOLD - 1);

    logic [SYNC_LEVELS-1:0] sync_q;
    logic                   sync_n;
    logic                   sync_rising;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             aon_q, aon_d;
    logic             mem_q, mem_d;
    logic             core_q, core_d;
    logic [1:0]       cause_q, cause_d;
    logic             cnt_zero;
    logic             warm_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_LEVELS-2:0], 1'b1};
        end
    end

    assign sync_n = sync_q[SYNC_LEVELS-1];
    // POR leaves on the same edge that sync_n rises, so the AON hold is counted from that edge.
    assign sync_rising = sync_q[SYNC_LEVELS-2];

    assign cnt_zero = (cnt_q == '0);
    assign warm_req = wdg_rst_req | sw_rst_req | dbg_ndmreset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_POR;
            cnt_q   <= '0;
            aon_q   <= 1'b0;
            mem_q   <= 1'b0;
            core_q  <= 1'b0;
            cause_q <= CAUSE_POR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            aon_q   <= aon_d;
            mem_q   <= mem_d;
            core_q  <= core_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        aon_d   = aon_q;
        mem_d   = mem_q;
        core_d  = core_q;
        cause_d = cause_q;

        case (state_q)
            ST_POR: begin
                aon_d  = 1'b0;
                mem_d  = 1'b0;
                core_d = 1'b0;
                if (sync_rising) begin
                    state_d = ST_AON;
                    cnt_d   = AON_LOAD;
                end
            end
            ST_AON: begin
                if (sync_n) begin
                    if (cnt_zero) begin
                        state_d = ST_MEM;
                        cnt_d   = MEM_LOAD;
                        aon_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_MEM: begin
                if (sync_n) begin
                    if (cnt_zero) begin
                        state_d = ST_CORE;
                        cnt_d   = CORE_LOAD;
                        mem_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_CORE: begin
                if (sync_n) begin
                    if (cnt_zero) begin
                        state_d = ST_RUN;
                        core_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (sync_n && warm_req) begin
                    state_d = ST_WARM;
                    cnt_d   = WARM_LOAD;
                    mem_d   = 1'b0;
                    core_d  = 1'b0;
                    if (wdg_rst_req) begin
                        cause_d = CAUSE_WDG;
                    end else if (dbg_ndmreset) begin
                        cause_d = CAUSE_DBG;
                    end else begin
                        cause_d = CAUSE_SW;
                    end
                end
            end
            ST_WARM: begin
                // A held ndmreset parks the counter at zero until the debugger lets go.
                if (sync_n) begin
                    if (cnt_zero) begin
                        if (!dbg_ndmreset) begin
                            state_d = ST_MEM;
                            cnt_d   = MEM_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_POR;
                cnt_d   = '0;
                aon_d   = 1'b0;
                mem_d   = 1'b0;
                core_d  = 1'b0;
            end
        endcase
    end

    // Scan bypass sits after the registers so test can drive every domain straight from rst_n.
    assign rst_aon_n  = test_mode ? rst_n : aon_q;
    assign rst_mem_n  = test_mode ? rst_n : mem_q;
    assign rst_core_n = test_mode ? rst_n : core_q;
    assign rst_cause  = cause_q;
    assign busy       = (state_q != ST_RUN);

endmodule

// File: tb/tb_e203_reset_seq.sv
// tb/tb_e203_reset_seq.sv - Self-checking bench for e203_reset_seq against an edge-arithmetic
// model of domain release times.
module tb_e203_reset_seq;

    localparam int S   = 2;
    localparam int A   = 4;
    localparam int M   = 8;
    localparam int C   = 16;
    localparam int W   = 8;
    localparam int BIG = 1 << 30;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       test_mode;
    logic       wdg_rst_req;
    logic       sw_rst_req;
    logic       dbg_ndmreset;
    logic       rst_aon_n;
    logic       rst_mem_n;
    logic       rst_core_n;
    logic [1:0] rst_cause;
    logic       busy;

    int         e;
    int         aon_rise;
    int         mem_rise;
    int         core_rise;
    int         warm_exit;
    bit         warm_active;
    logic [1:0] exp_cause;
    int         n_assert;
    int         n_fail;

    e203_reset_seq #(
        .SYNC_LEVELS(S),
        .AON_HOLD(A),
        .MEM_HOLD(M),
        .CORE_HOLD(C),
        .WARM_HOLD(W),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .test_mode(test_mode),
        .wdg_rst_req(wdg_rst_req),
        .sw_rst_req(sw_rst_req),
        .dbg_ndmreset(dbg_ndmreset),
        .rst_aon_n(rst_aon_n),
        .rst_mem_n(rst_mem_n),
        .rst_core_n(rst_core_n),
        .rst_cause(rst_cause),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, expv, e);
        end
    endtask

    task automatic check_all();
        logic ea, em, ec, eb;
        ea = rst_n && (e >= aon_rise);
        em = rst_n && (e >= mem_rise);
        ec = rst_n && (e >= core_rise);
        eb = !(rst_n && (e >= core_rise));
        if (test_mode) begin
            ea = rst_n;
            em = rst_n;
            ec = rst_n;
        end
        chk("rst_aon_n", {1'b0, rst_aon_n}, {1'b0, ea});
        chk("rst_mem_n", {1'b0, rst_mem_n}, {1'b0, em});
        chk("rst_core_n", {1'b0, rst_core_n}, {1'b0, ec});
        chk("busy", {1'b0, busy}, {1'b0, eb});
        chk("rst_cause", rst_cause, exp_cause);
    endtask

    task automatic model_reset();
        aon_rise    = BIG;
        mem_rise    = BIG;
        core_rise   = BIG;
        exp_cause   = 2'd0;
        warm_active = 1'b0;
    endtask

    task automatic release_rst();
        rst_n     = 1'b1;
        e         = 0;
        aon_rise  = S + A;
        mem_rise  = aon_rise + M;
        core_rise = mem_rise + C;
    endtask

    // One clock: model sees the same sampled inputs as the DUT, then outputs are checked at negedge.
    task automatic cycle();
        @(posedge clk);
        e++;
        if (rst_n) begin
            if (warm_active && e == warm_exit) begin
                if (dbg_ndmreset) begin
                    warm_exit++;
                end else begin
                    warm_active = 1'b0;
                    mem_rise    = e + M;
                    core_rise   = mem_rise + C;
                end
            end else if (!warm_active && (e - 1) >= core_rise &&
                         (wdg_rst_req || sw_rst_req || dbg_ndmreset)) begin
                exp_cause   = wdg_rst_req ? 2'd1 : (dbg_ndmreset ? 2'd2 : 2'd3);
                warm_active = 1'b1;
                warm_exit   = e + W;
                mem_rise    = BIG;
                core_rise   = BIG;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 500 && e < target; i++) cycle();
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        e            = 0;
        rst_n        = 1'b0;
        test_mode    = 1'b0;
        wdg_rst_req  = 1'b0;
        sw_rst_req   = 1'b0;
        dbg_ndmreset = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (3) cycle();

        release_rst();
        run_to(35);

        for (int k = 0; k < 10; k++) begin
            int kind;
            int len;
            repeat ($urandom_range(0, 6)) cycle();
            kind = (k < 3) ? k : int'($urandom_range(0, 3));
            if (kind == 3) kind = 4;
            case (kind)
                0: begin
                    wdg_rst_req = 1'b1;
                    cycle();
                    wdg_rst_req = 1'b0;
                end
                1: begin
                    wdg_rst_req  = 1'b1;
                    sw_rst_req   = 1'b1;
                    dbg_ndmreset = 1'b1;
                    cycle();
                    wdg_rst_req  = 1'b0;
                    sw_rst_req   = 1'b0;
                    dbg_ndmreset = 1'b0;
                end
                2, 4: begin
                    len = (kind == 2) ? 40 : int'($urandom_range(1, 45));
                    dbg_ndmreset = 1'b1;
                    for (int i = 0; i < len; i++) begin
                        sw_rst_req = (i > 0) && ($urandom_range(0, 3) == 0);
                        cycle();
                    end
                    dbg_ndmreset = 1'b0;
                    sw_rst_req   = 1'b0;
                end
                default: begin
                    sw_rst_req = 1'b1;
                    cycle();
                    sw_rst_req = 1'b0;
                end
            endcase
            for (int i = 0; i < 200 && e < core_rise; i++) begin
                sw_rst_req  = ($urandom_range(0, 4) == 0);
                wdg_rst_req = ($urandom_range(0, 6) == 0);
                cycle();
            end
            sw_rst_req  = 1'b0;
            wdg_rst_req = 1'b0;
            cycle();
        end

        // Reset dropped while the TCM hold is counting.
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) cycle();
        release_rst();
        run_to(10);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        #1;
        release_rst();
        run_to(35);

        // Scan bypass: outputs follow rst_n between clock edges.
        test_mode = 1'b1;
        #1;
        check_all();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        release_rst();
        #1;
        check_all();
        run_to(8);
        test_mode = 1'b0;
        #1;
        check_all();
        run_to(35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
